// File: rtl/shift_pkg.sv
// Shared types, constants and helpers for the shift arbiter slice.
package shift_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    // Operation encoding carried on req_op; OP_RSV behaves as a left shift.
    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_RSV = 2'b11
    } shift_op_e;

    // Output register occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_e;

    // Mirror a word end-for-end so a left shifter can perform right shifts.
    function automatic logic [XLEN-1:0] bit_rev32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = '0;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = v[XLEN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_left.sv
// Logarithmic 32-bit left barrel shifter, zero fill, purely combinational.
module shift_left
    import shift_pkg::*;
(
    input  logic [XLEN-1:0]    data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic [XLEN-1:0]    data_o
);

    // stg[k] holds the operand after the first k shift-amount bits are applied
    logic [SHAMT_W:0][XLEN-1:0] stg;

    assign stg[0] = data_i;

    for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
        assign stg[i+1] = shamt_i[i] ? (stg[i] << (1 << i)) : stg[i];
    end

    assign data_o = stg[SHAMT_W];

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one left barrel shifter between NUM_REQ
// requesters. Right shifts reuse the left shifter by bit reversal; the
// result sits in a one-entry output register with a valid/ready handshake.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*XLEN-1:0]    req_data,
    input  logic [NUM_REQ*SHAMT_W-1:0] req_shamt,
    input  logic [NUM_REQ*2-1:0]       req_op,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [XLEN-1:0]            rsp_data,
    output logic [ID_W-1:0]            rsp_id
);

    rsp_state_e      state_q;
    logic [XLEN-1:0] rsp_data_q;
    logic [ID_W-1:0] rsp_id_q;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    logic            can_accept;
    logic            gnt_found;
    logic [ID_W-1:0] gnt_idx;
    logic            fire;

    assign rsp_valid  = (state_q == ST_FULL);
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = rsp_id_q;
    assign can_accept = (state_q == ST_EMPTY) | (rsp_valid & rsp_ready);

    // Round-robin pick: first valid at or above rr_ptr, else first valid below it
    always_comb begin
        logic hi_found;
        logic lo_found;
        logic [ID_W-1:0] hi_idx;
        logic [ID_W-1:0] lo_idx;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && (ID_W'(i) >= rr_ptr_q) && !hi_found) begin
                hi_found = 1'b1;
                hi_idx   = ID_W'(i);
            end
            if (req_valid[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = ID_W'(i);
            end
        end
        gnt_found = hi_found | lo_found;
        gnt_idx   = hi_found ? hi_idx : lo_idx;
    end

    // One-hot accept toward the granted requester while the output slot can take data
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_found && can_accept && (gnt_idx == ID_W'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    assign fire     = gnt_found & can_accept;
    assign rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    // ------------------------------------------------------------------
    // Datapath: select the granted operand, then shift
    // ------------------------------------------------------------------
    logic [XLEN-1:0]    op_x;
    logic [SHAMT_W-1:0] op_s;
    shift_op_e          op_sel;
    logic               is_right;
    logic               sra_neg;
    logic [XLEN-1:0]    sh_in;
    logic [XLEN-1:0]    sh_out;
    logic [XLEN-1:0]    result;

    // Operand mux indexed by the current grant
    always_comb begin
        op_x   = '0;
        op_s   = '0;
        op_sel = OP_SLL;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                op_x   = req_data[i*XLEN +: XLEN];
                op_s   = req_shamt[i*SHAMT_W +: SHAMT_W];
                op_sel = shift_op_e'(req_op[i*2 +: 2]);
            end
        end
    end

    // Right shifts run reversed; a negative SRA is done as an inverted SRL of the
    // inverted operand so the vacated bits fill with ones
    always_comb begin
        is_right = (op_sel == OP_SRL) || (op_sel == OP_SRA);
        sra_neg  = (op_sel == OP_SRA) && op_x[XLEN-1];
        if (!is_right) begin
            sh_in = op_x;
        end else if (sra_neg) begin
            sh_in = bit_rev32(~op_x);
        end else begin
            sh_in = bit_rev32(op_x);
        end
    end

    shift_left u_shift_left (
        .data_i  (sh_in),
        .shamt_i (op_s),
        .data_o  (sh_out)
    );

    // Undo the reversal (and inversion) on the way out
    always_comb begin
        if (!is_right) begin
            result = sh_out;
        end else if (sra_neg) begin
            result = ~bit_rev32(sh_out);
        end else begin
            result = bit_rev32(sh_out);
        end
    end

    // Output slot FSM: load on fire, drain on consumer accept, hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            rr_ptr_q   <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (fire) begin
                        state_q    <= ST_FULL;
                        rsp_data_q <= result;
                        rsp_id_q   <= gnt_idx;
                        rr_ptr_q   <= rr_ptr_d;
                    end
                end
                ST_FULL: begin
                    if (fire) begin
                        rsp_data_q <= result;
                        rsp_id_q   <= gnt_idx;
                        rr_ptr_q   <= rr_ptr_d;
                    end else if (rsp_ready) begin
                        state_q <= ST_EMPTY;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with two requesters.
module tb_shift_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

    logic                   clk;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*32-1:0]  req_data;
    logic [NUM_REQ*5-1:0]   req_shamt;
    logic [NUM_REQ*2-1:0]   req_op;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [31:0]            rsp_data;
    logic [ID_W-1:0]        rsp_id;

    int n_vec = 0;
    int n_err = 0;

    shift_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_shamt (req_shamt),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Independent reference using native shift operators
    function automatic logic [31:0] model(input logic [31:0] x, input logic [4:0] s,
                                          input logic [1:0] op);
        logic [31:0] r;
        case (op)
            2'b01:   r = x >> s;
            2'b10:   r = 32'($signed(x) >>> s);
            default: r = x << s;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single request from requester r, consumer always ready
    task automatic single(input string tag, input int r, input logic [31:0] x,
                          input logic [4:0] s, input logic [1:0] op, input logic [31:0] exp);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        oh[r] = 1'b1;
        req_valid = oh;
        req_data[r*32 +: 32] = x;
        req_shamt[r*5 +: 5]  = s;
        req_op[r*2 +: 2]     = op;
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'(oh));
        tick();
        req_valid = '0;
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_data"}, rsp_data, exp);
        chk({tag, "_id"}, 32'(rsp_id), 32'(r));
    endtask

    initial begin
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] rx;
        logic [4:0]  rs;
        logic [1:0]  ro;
        int          rr;

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_shamt = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        chk("reset_data", rsp_data, 32'd0);
        chk("reset_id", 32'(rsp_id), 32'd0);
        rst = 1'b0;

        // Park a result from requester 1 with the consumer stalled, then reset
        req_valid = 2'b10;
        req_data[32 +: 32] = 32'hDEAD_BEEF;
        tick();
        req_valid = '0;
        chk("pend_valid", 32'(rsp_valid), 32'd1);
        chk("pend_data", rsp_data, 32'hDEAD_BEEF);
        chk("pend_id", 32'(rsp_id), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_data", rsp_data, 32'd0);
        chk("midrst_id", 32'(rsp_id), 32'd0);

        // Round-robin: both valid, consumer ready, s=0 SLL passes the data through
        d0 = 32'h1111_0000;
        d1 = 32'h2222_0001;
        req_data  = {d1, d0};
        req_shamt = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            chk("rr_valid", 32'(rsp_valid), 32'd1);
            chk("rr_id", 32'(rsp_id), 32'(k % 2));
            chk("rr_data", rsp_data, (k % 2 == 0) ? d0 : d1);
        end

        // Backpressure: last result came from requester 1, so it must hold
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_ready", 32'(req_ready), 32'd0);
            tick();
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_id", 32'(rsp_id), 32'd1);
            chk("bp_data", rsp_data, d1);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'd1);
        tick();
        chk("bp_release_id", 32'(rsp_id), 32'd0);
        chk("bp_release_data", rsp_data, d0);
        req_valid = '0;
        tick();
        chk("drain_valid", 32'(rsp_valid), 32'd0);

        // Single-op correctness on requester 0
        single("sll4", 0, 32'h8000_00F1, 5'd4, 2'b00, 32'h0000_0F10);
        single("srl4", 0, 32'h8000_00F1, 5'd4, 2'b01, 32'h0800_000F);
        single("sra4", 0, 32'h8000_00F1, 5'd4, 2'b10, 32'hF800_000F);
        single("sll0", 0, 32'h8000_00F1, 5'd0, 2'b00, 32'h8000_00F1);
        single("srl0", 0, 32'h8000_00F1, 5'd0, 2'b01, 32'h8000_00F1);
        single("sra0", 0, 32'h8000_00F1, 5'd0, 2'b10, 32'h8000_00F1);
        single("rsv0", 0, 32'h8000_00F1, 5'd0, 2'b11, 32'h8000_00F1);

        // Boundaries
        single("sra31", 0, 32'hFFFF_FFFF, 5'd31, 2'b10, 32'hFFFF_FFFF);
        single("srl31", 0, 32'hFFFF_FFFF, 5'd31, 2'b01, 32'h0000_0001);
        single("sll31", 0, 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000);
        single("rsv3",  0, 32'h0000_0001, 5'd3,  2'b11, 32'h0000_0008);
        single("sra_pos", 1, 32'h7000_0000, 5'd4, 2'b10, 32'h0700_0000);
        single("sra_r1", 1, 32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF);

        // Random operands checked against the native-operator model
        for (int k = 0; k < 200; k++) begin
            rr = int'($urandom_range(0, NUM_REQ - 1));
            rx = $urandom;
            rs = 5'($urandom_range(0, 31));
            ro = 2'($urandom_range(0, 3));
            single("rand", rr, rx, rs, ro, model(rx, rs, ro));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop so the run always ends on its own
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
